// File: rtl/display_scan_if.sv
// Bus between the measurement stage and the display scan controller.
// LOAD is a one-cycle strobe with no ready/backpressure: BCD_IN is captured
// on every rising CLK edge where LOAD=1, and the controller always accepts it.
// A later LOAD before the frame boundary overwrites the earlier value.
interface display_scan_if;
  logic [15:0] BCD_IN;
  logic        LOAD;
  logic        BLANK_LZ;
  logic        A;
  logic        B;
  logic        DIGIT_EN;
  logic [3:0]  NIBBLE;
  logic [6:0]  SEG;
  logic        FRAME;

  // Producer side: measurement stage (or testbench) driving the controller.
  modport master (
    output BCD_IN, LOAD, BLANK_LZ,
    input  A, B, DIGIT_EN, NIBBLE, SEG, FRAME
  );

  // Controller side.
  modport slave (
    input  BCD_IN, LOAD, BLANK_LZ,
    output A, B, DIGIT_EN, NIBBLE, SEG, FRAME
  );
endinterface

// File: rtl/display_scan_controller.sv
// Digit-scan sequencer for a 4-digit seven-segment display. Walks a 2-bit
// digit index (A/B to a 2-to-4 decoder), drives the shared active-low segment
// bus, holds DIGIT_EN low for a guard window at the start of every slot,
// blanks leading zeros on request and only swaps in a new value at the
// frame boundary (index 3 -> 0) so a frame never mixes two readings.
module display_scan_controller #(
  parameter int SCAN_DIV  = 100000,
  parameter int GUARD_CYC = 64
) (
  input  logic          CLK,
  input  logic          RESET_N,
  display_scan_if.slave bus
);

  localparam int              CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   LP_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW:0]     LP_GUARD = (CW + 1)'(GUARD_CYC);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_disp;
  logic [15:0]   r_pend;
  logic          r_pend_flag;

  logic          r_a;
  logic          r_b;
  logic          r_digit_en;
  logic [3:0]    r_nibble;
  logic [6:0]    r_seg;
  logic          r_frame;

  logic          w_tick;
  logic          w_wrap;
  logic [3:0]    w_nibble;
  logic          w_blank;
  logic          w_guard_done;
  logic [6:0]    w_seg_dec;

  assign w_tick       = (r_cnt == LP_LAST);
  assign w_wrap       = w_tick & (r_idx == 2'd3);
  assign w_guard_done = ({1'b0, r_cnt} >= LP_GUARD);

  // Select the digit being scanned and decide whether it is a leading zero.
  always_comb begin
    w_nibble = r_disp[3:0];
    w_blank  = 1'b0;
    case (r_idx)
      2'd0: begin
        w_nibble = r_disp[3:0];
        w_blank  = 1'b0;
      end
      2'd1: begin
        w_nibble = r_disp[7:4];
        w_blank  = bus.BLANK_LZ & (r_disp[15:4] == 12'h000);
      end
      2'd2: begin
        w_nibble = r_disp[11:8];
        w_blank  = bus.BLANK_LZ & (r_disp[15:8] == 8'h00);
      end
      default: begin
        w_nibble = r_disp[15:12];
        w_blank  = bus.BLANK_LZ & (r_disp[15:12] == 4'h0);
      end
    endcase
  end

  // BCD to active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash.
  always_comb begin
    w_seg_dec = 7'h3F;
    case (w_nibble)
      4'd0:    w_seg_dec = 7'h40;
      4'd1:    w_seg_dec = 7'h79;
      4'd2:    w_seg_dec = 7'h24;
      4'd3:    w_seg_dec = 7'h30;
      4'd4:    w_seg_dec = 7'h19;
      4'd5:    w_seg_dec = 7'h12;
      4'd6:    w_seg_dec = 7'h02;
      4'd7:    w_seg_dec = 7'h78;
      4'd8:    w_seg_dec = 7'h00;
      4'd9:    w_seg_dec = 7'h10;
      default: w_seg_dec = 7'h3F;
    endcase
  end

  // Slot prescaler and digit index.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
      if (w_tick) r_idx <= r_idx + 2'd1;
    end
  end

  // Pending/display double buffer; the display copy only moves at the frame wrap.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_disp      <= 16'h0000;
      r_pend      <= 16'h0000;
      r_pend_flag <= 1'b0;
    end else begin
      if (w_wrap && r_pend_flag) r_disp <= r_pend;
      if (bus.LOAD) begin
        r_pend      <= bus.BCD_IN;
        r_pend_flag <= 1'b1;
      end else if (w_wrap) begin
        r_pend_flag <= 1'b0;
      end
    end
  end

  // Registered outputs, one cycle behind the scan state.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_digit_en <= 1'b0;
      r_nibble   <= 4'h0;
      r_seg      <= 7'h7F;
      r_frame    <= 1'b0;
    end else begin
      r_a        <= r_idx[1];
      r_b        <= r_idx[0];
      r_digit_en <= w_guard_done & ~w_blank;
      r_nibble   <= w_nibble;
      r_seg      <= w_blank ? 7'h7F : w_seg_dec;
      r_frame    <= w_wrap;
    end
  end

  assign bus.A        = r_a;
  assign bus.B        = r_b;
  assign bus.DIGIT_EN = r_digit_en;
  assign bus.NIBBLE   = r_nibble;
  assign bus.SEG      = r_seg;
  assign bus.FRAME    = r_frame;

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with SCAN_DIV=4, GUARD_CYC=1.
// After each reset release, edge k (k=1,2,...) produces outputs for
// slot (k-1)/4 mod 4, guard when (k-1)%4==0, FRAME when k%16==0, and frame
// number (k-1)/16 shows the value committed at the previous wrap.
module tb_display_scan_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   k_edges = 0;

  display_scan_if bus_if ();

  display_scan_controller #(.SCAN_DIV(4), .GUARD_CYC(1)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .bus     (bus_if.slave)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    k_edges++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.LOAD = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    k_edges = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.LOAD = 1'b0;
    bus_if.BCD_IN = 16'h0000;
    bus_if.BLANK_LZ = 1'b0;
    step();
    step();
    total++; if ({bus_if.A, bus_if.B} !== 2'd0) begin bad++; $display("FAIL reset_ab got=%0d want=0", {bus_if.A, bus_if.B}); end
    total++; if (bus_if.DIGIT_EN !== 1'b0) begin bad++; $display("FAIL reset_en got=%b want=0", bus_if.DIGIT_EN); end
    total++; if (bus_if.NIBBLE !== 4'h0) begin bad++; $display("FAIL reset_nib got=%h want=0", bus_if.NIBBLE); end
    total++; if (bus_if.SEG !== 7'h7F) begin bad++; $display("FAIL reset_seg got=%h want=7f", bus_if.SEG); end
    total++; if (bus_if.FRAME !== 1'b0) begin bad++; $display("FAIL reset_frame got=%b want=0", bus_if.FRAME); end
    rst_n = 1'b1;
    k_edges = 0;
  endtask

  task automatic test_scan();
    int ix;
    int frames;
    logic exp_en;
    frames = 0;
    do_reset();
    bus_if.BLANK_LZ = 1'b0;
    for (int c = 0; c < 16; c++) begin
      step();
      ix = ((k_edges - 1) / 4) % 4;
      exp_en = ((k_edges - 1) % 4) != 0;
      if (bus_if.FRAME === 1'b1) frames++;
      total++; if ({bus_if.A, bus_if.B} !== 2'(ix)) begin bad++; $display("FAIL scan_ab k=%0d got=%0d want=%0d", k_edges, {bus_if.A, bus_if.B}, ix); end
      total++; if (bus_if.DIGIT_EN !== exp_en) begin bad++; $display("FAIL scan_en k=%0d got=%b want=%b", k_edges, bus_if.DIGIT_EN, exp_en); end
      total++; if (bus_if.SEG !== 7'h40) begin bad++; $display("FAIL scan_seg k=%0d got=%h want=40", k_edges, bus_if.SEG); end
      total++; if (bus_if.FRAME !== (k_edges == 16)) begin bad++; $display("FAIL scan_frame k=%0d got=%b", k_edges, bus_if.FRAME); end
    end
    total++; if (frames != 1) begin bad++; $display("FAIL scan_frame_count got=%0d want=1", frames); end
  endtask

  task automatic test_lz_blank();
    int ix, fr;
    logic [27:0] es;
    logic [15:0] en;
    logic [3:0]  eb;
    logic exp_en;
    do_reset();
    bus_if.BLANK_LZ = 1'b1;
    for (int c = 0; c < 32; c++) begin
      bus_if.LOAD = 1'b0;
      if (k_edges + 1 == 2) begin bus_if.LOAD = 1'b1; bus_if.BCD_IN = 16'h0120; end
      step();
      bus_if.LOAD = 1'b0;
      fr = (k_edges - 1) / 16;
      ix = ((k_edges - 1) / 4) % 4;
      if (fr == 0) begin es = {7'h7F, 7'h7F, 7'h7F, 7'h40}; en = 16'h0000; eb = 4'b1110; end
      else         begin es = {7'h7F, 7'h79, 7'h24, 7'h40}; en = 16'h0120; eb = 4'b1000; end
      exp_en = (((k_edges - 1) % 4) != 0) && !eb[ix];
      total++; if ({bus_if.A, bus_if.B} !== 2'(ix)) begin bad++; $display("FAIL lz_ab k=%0d got=%0d want=%0d", k_edges, {bus_if.A, bus_if.B}, ix); end
      total++; if (bus_if.NIBBLE !== en[4*ix +: 4]) begin bad++; $display("FAIL lz_nib k=%0d got=%h want=%h", k_edges, bus_if.NIBBLE, en[4*ix +: 4]); end
      total++; if (bus_if.SEG !== es[7*ix +: 7]) begin bad++; $display("FAIL lz_seg k=%0d got=%h want=%h", k_edges, bus_if.SEG, es[7*ix +: 7]); end
      total++; if (bus_if.DIGIT_EN !== exp_en) begin bad++; $display("FAIL lz_en k=%0d got=%b want=%b", k_edges, bus_if.DIGIT_EN, exp_en); end
      total++; if (bus_if.FRAME !== ((k_edges % 16) == 0)) begin bad++; $display("FAIL lz_frame k=%0d got=%b", k_edges, bus_if.FRAME); end
    end
  endtask

  task automatic test_back_to_back();
    int ix, fr;
    logic [27:0] es;
    logic [15:0] en;
    logic exp_en;
    do_reset();
    bus_if.BLANK_LZ = 1'b0;
    for (int c = 0; c < 32; c++) begin
      bus_if.LOAD = 1'b0;
      if (k_edges + 1 == 3) begin bus_if.LOAD = 1'b1; bus_if.BCD_IN = 16'h1111; end
      if (k_edges + 1 == 8) begin bus_if.LOAD = 1'b1; bus_if.BCD_IN = 16'h9876; end
      step();
      bus_if.LOAD = 1'b0;
      fr = (k_edges - 1) / 16;
      ix = ((k_edges - 1) / 4) % 4;
      if (fr == 0) begin es = {4{7'h40}}; en = 16'h0000; end
      else         begin es = {7'h10, 7'h00, 7'h78, 7'h02}; en = 16'h9876; end
      exp_en = ((k_edges - 1) % 4) != 0;
      total++; if (bus_if.NIBBLE !== en[4*ix +: 4]) begin bad++; $display("FAIL b2b_nib k=%0d got=%h want=%h", k_edges, bus_if.NIBBLE, en[4*ix +: 4]); end
      total++; if (bus_if.SEG !== es[7*ix +: 7]) begin bad++; $display("FAIL b2b_seg k=%0d got=%h want=%h", k_edges, bus_if.SEG, es[7*ix +: 7]); end
      total++; if (bus_if.DIGIT_EN !== exp_en) begin bad++; $display("FAIL b2b_en k=%0d got=%b want=%b", k_edges, bus_if.DIGIT_EN, exp_en); end
    end
  endtask

  task automatic test_load_at_wrap();
    int ix, fr;
    logic [27:0] es;
    logic [15:0] en;
    do_reset();
    bus_if.BLANK_LZ = 1'b0;
    for (int c = 0; c < 48; c++) begin
      bus_if.LOAD = 1'b0;
      if (k_edges + 1 == 5)  begin bus_if.LOAD = 1'b1; bus_if.BCD_IN = 16'h1234; end
      if (k_edges + 1 == 16) begin bus_if.LOAD = 1'b1; bus_if.BCD_IN = 16'h5678; end
      step();
      bus_if.LOAD = 1'b0;
      fr = (k_edges - 1) / 16;
      ix = ((k_edges - 1) / 4) % 4;
      if (fr == 0)      begin es = {4{7'h40}}; en = 16'h0000; end
      else if (fr == 1) begin es = {7'h79, 7'h24, 7'h30, 7'h19}; en = 16'h1234; end
      else              begin es = {7'h12, 7'h02, 7'h78, 7'h00}; en = 16'h5678; end
      total++; if ({bus_if.A, bus_if.B} !== 2'(ix)) begin bad++; $display("FAIL wrap_ab k=%0d got=%0d want=%0d", k_edges, {bus_if.A, bus_if.B}, ix); end
      total++; if (bus_if.NIBBLE !== en[4*ix +: 4]) begin bad++; $display("FAIL wrap_nib k=%0d got=%h want=%h", k_edges, bus_if.NIBBLE, en[4*ix +: 4]); end
      total++; if (bus_if.SEG !== es[7*ix +: 7]) begin bad++; $display("FAIL wrap_seg k=%0d got=%h want=%h", k_edges, bus_if.SEG, es[7*ix +: 7]); end
      total++; if (bus_if.FRAME !== ((k_edges % 16) == 0)) begin bad++; $display("FAIL wrap_frame k=%0d got=%b", k_edges, bus_if.FRAME); end
    end
  endtask

  task automatic test_dash();
    int ix, fr;
    logic [27:0] es;
    logic [15:0] en;
    logic [3:0]  eb;
    logic exp_en;
    do_reset();
    bus_if.BLANK_LZ = 1'b1;
    for (int c = 0; c < 48; c++) begin
      bus_if.LOAD = 1'b0;
      if (k_edges + 1 == 2)  begin bus_if.LOAD = 1'b1; bus_if.BCD_IN = 16'hA000; end
      if (k_edges + 1 == 20) begin bus_if.LOAD = 1'b1; bus_if.BCD_IN = 16'h0005; end
      step();
      bus_if.LOAD = 1'b0;
      fr = (k_edges - 1) / 16;
      ix = ((k_edges - 1) / 4) % 4;
      if (fr == 0)      begin es = {7'h7F, 7'h7F, 7'h7F, 7'h40}; en = 16'h0000; eb = 4'b1110; end
      else if (fr == 1) begin es = {7'h3F, 7'h40, 7'h40, 7'h40}; en = 16'hA000; eb = 4'b0000; end
      else              begin es = {7'h7F, 7'h7F, 7'h7F, 7'h12}; en = 16'h0005; eb = 4'b1110; end
      exp_en = (((k_edges - 1) % 4) != 0) && !eb[ix];
      total++; if (bus_if.NIBBLE !== en[4*ix +: 4]) begin bad++; $display("FAIL dash_nib k=%0d got=%h want=%h", k_edges, bus_if.NIBBLE, en[4*ix +: 4]); end
      total++; if (bus_if.SEG !== es[7*ix +: 7]) begin bad++; $display("FAIL dash_seg k=%0d got=%h want=%h", k_edges, bus_if.SEG, es[7*ix +: 7]); end
      total++; if (bus_if.DIGIT_EN !== exp_en) begin bad++; $display("FAIL dash_en k=%0d got=%b want=%b", k_edges, bus_if.DIGIT_EN, exp_en); end
    end
  endtask

  task automatic test_reset_mid();
    int ix;
    logic exp_en;
    do_reset();
    bus_if.BLANK_LZ = 1'b0;
    for (int c = 0; c < 9; c++) begin
      bus_if.LOAD = 1'b0;
      if (k_edges + 1 == 6) begin bus_if.LOAD = 1'b1; bus_if.BCD_IN = 16'h4444; end
      step();
      bus_if.LOAD = 1'b0;
      total++; if (bus_if.SEG !== 7'h40) begin bad++; $display("FAIL rmid_pre_seg k=%0d got=%h want=40", k_edges, bus_if.SEG); end
    end
    rst_n = 1'b0;
    step();
    total++; if ({bus_if.A, bus_if.B} !== 2'd0) begin bad++; $display("FAIL rmid_ab got=%0d want=0", {bus_if.A, bus_if.B}); end
    total++; if (bus_if.DIGIT_EN !== 1'b0) begin bad++; $display("FAIL rmid_en got=%b want=0", bus_if.DIGIT_EN); end
    total++; if (bus_if.NIBBLE !== 4'h0) begin bad++; $display("FAIL rmid_nib got=%h want=0", bus_if.NIBBLE); end
    total++; if (bus_if.SEG !== 7'h7F) begin bad++; $display("FAIL rmid_seg got=%h want=7f", bus_if.SEG); end
    total++; if (bus_if.FRAME !== 1'b0) begin bad++; $display("FAIL rmid_frame got=%b want=0", bus_if.FRAME); end
    rst_n = 1'b1;
    k_edges = 0;
    for (int c = 0; c < 32; c++) begin
      step();
      ix = ((k_edges - 1) / 4) % 4;
      exp_en = ((k_edges - 1) % 4) != 0;
      total++; if ({bus_if.A, bus_if.B} !== 2'(ix)) begin bad++; $display("FAIL rmid_post_ab k=%0d got=%0d want=%0d", k_edges, {bus_if.A, bus_if.B}, ix); end
      total++; if (bus_if.NIBBLE !== 4'h0) begin bad++; $display("FAIL rmid_post_nib k=%0d got=%h want=0", k_edges, bus_if.NIBBLE); end
      total++; if (bus_if.SEG !== 7'h40) begin bad++; $display("FAIL rmid_post_seg k=%0d got=%h want=40", k_edges, bus_if.SEG); end
      total++; if (bus_if.DIGIT_EN !== exp_en) begin bad++; $display("FAIL rmid_post_en k=%0d got=%b want=%b", k_edges, bus_if.DIGIT_EN, exp_en); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus_if.LOAD = 1'b0;
    bus_if.BCD_IN = 16'h0000;
    bus_if.BLANK_LZ = 1'b0;
    test_reset();
    test_scan();
    test_lz_blank();
    test_back_to_back();
    test_load_at_wrap();
    test_dash();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
